wallace_mul_pipe: RTL

- Parametrised, fully pipelined Wallace-tree multiplier. Successor to the fixed 32x32 unsigned pipelined multiplier.
- Adds four things the 32x32 unit lacks:
  - WIDTH generalisation.
  - Per-operation signed/unsigned mode.
  - valid/ready handshake with global stall.
  - Tag passthrough and asynchronous reset.
- Sits in the integer datapath, feeding the execute-stage result mux.

---
 rtl/wallace_pkg.sv | 33 +++
 rtl/wallace_mul_pipe_csa_level.sv | 28 ++
 rtl/wallace_mul_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier: CSA row
// counts per level, level count, and the Baugh-Wooley correction constant.
package wallace_pkg;

  function automatic int csa_rows_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int csa_rows_after(input int rows, input int lvl);
    int r;
    r = rows;
    for (int k = 0; k < lvl; k++) r = csa_rows_next(r);
    return r;
  endfunction

  function automatic int csa_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = csa_rows_next(r);
      n++;
    end
    return n;
  endfunction

  // Signed n x n Baugh-Wooley needs +2^n and +2^(2n-1) on top of the rows.
  function automatic logic [127:0] bw_correction(input int width);
    return (128'd1 << width) | (128'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/wallace_mul_pipe_csa_level.sv
// One combinational 3:2 carry-save level: each group of three rows becomes a
// sum row and a left-shifted carry row; leftover rows pass straight through.
module csa_level
  import wallace_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = csa_rows_next(N_IN),
  parameter int W     = 8
) (
  input  logic [N_IN-1:0][W-1:0]  in_rows,
  output logic [N_OUT-1:0][W-1:0] out_rows
);

  localparam int GROUPS = N_IN / 3;
  localparam int LEFT   = N_IN % 3;

  always_comb begin
    out_rows = '0;
    for (int g = 0; g < GROUPS; g++) begin
      out_rows[2*g]   = in_rows[3*g] ^ in_rows[3*g+1] ^ in_rows[3*g+2];
      out_rows[2*g+1] = ((in_rows[3*g] & in_rows[3*g+1]) |
                         (in_rows[3*g] & in_rows[3*g+2]) |
                         (in_rows[3*g+1] & in_rows[3*g+2])) << 1;
    end
    for (int k = 0; k < LEFT; k++) out_rows[2*GROUPS+k] = in_rows[3*GROUPS+k];
  end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Fully pipelined WIDTH x WIDTH Wallace-tree multiplier with signed/unsigned
// mode, tag passthrough and a valid/ready handshake stalled globally.
module wallace_mul_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W2     = 2 * WIDTH;
  localparam int ROWS   = WIDTH + 1;
  localparam int LEVELS = csa_levels(ROWS);
  localparam logic [W2-1:0] CORR = W2'(bw_correction(WIDTH));

  logic                     stall;
  logic [ROWS-1:0][W2-1:0]  pp_d;
  logic [ROWS-1:0][W2-1:0]  pp_q;
  logic                     s0_valid;
  logic [TAG_W-1:0]         s0_tag;
  logic [1:0][W2-1:0]       last_rows;
  logic                     last_valid;
  logic [TAG_W-1:0]         last_tag;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Terms where exactly one index is the sign bit get inverted in signed mode.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][i+j] = (in_a[j] & in_b[i]) ^
                       (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_d[WIDTH] = in_signed ? CORR : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s0_valid <= 1'b0;
    else if (!stall) s0_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      pp_q   <= pp_d;
      s0_tag <= in_tag;
    end
  end

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int N_IN  = csa_rows_after(ROWS, i);
    localparam int N_OUT = csa_rows_next(N_IN);

    logic [N_IN-1:0][W2-1:0]  d_rows;
    logic                     d_valid;
    logic [TAG_W-1:0]         d_tag;
    logic [N_OUT-1:0][W2-1:0] c_rows;
    logic [N_OUT-1:0][W2-1:0] q_rows;
    logic                     q_valid;
    logic [TAG_W-1:0]         q_tag;

    if (i == 0) begin : g_src
      assign d_rows  = pp_q;
      assign d_valid = s0_valid;
      assign d_tag   = s0_tag;
    end else begin : g_src
      assign d_rows  = g_lvl[i-1].q_rows;
      assign d_valid = g_lvl[i-1].q_valid;
      assign d_tag   = g_lvl[i-1].q_tag;
    end

    csa_level #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W2)) u_csa (
      .in_rows  (d_rows),
      .out_rows (c_rows)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q_valid <= 1'b0;
      else if (!stall) q_valid <= d_valid;
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        q_rows <= c_rows;
        q_tag  <= d_tag;
      end
    end
  end

  assign last_rows  = g_lvl[LEVELS-1].q_rows;
  assign last_valid = g_lvl[LEVELS-1].q_valid;
  assign last_tag   = g_lvl[LEVELS-1].q_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= last_valid;
      out_p     <= last_rows[0] + last_rows[1];
      out_tag   <= last_tag;
    end
  end

endmodule
